// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
//   Forwarding and hazard unit for the in-order MIPS pipeline. It keeps a
//   shift-register scoreboard of the destination writes in flight for DEPTH
//   stages after RF (1=EX, 2=MEM, 3=WB). For each RF source operand it finds
//   the youngest producer and decides one of three things: forward now
//   (RF-stage consumers), forward in EX (ALU consumers), or stall.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   rf_valid              valid instruction in RF
//   rf_rs, rf_rt          source register addresses
//   rf_use_rs, rf_use_rt  operand actually read
//   rf_early              operands consumed in RF (branch compare, jr)
//   rf_wr_en, rf_dst      instruction writes rf_dst (31 for jal)
//   rf_is_load            destination is produced by a load
//   flush                 kill the RF instruction (bubble into EX)
//   clr_cnt               clear stall_cnt
//   stall                 hold PC and IF/RF, bubble into EX (combinational)
//   rf_fwd_rs/rt          RF-stage source: 0 = regfile, k = stage k result
//   ex_fwd_rs/rt          registered source select for the instruction in EX
//   stall_cnt             saturating count of stall cycles
module fwd_hazard_scoreboard #(
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 3,
    parameter int ALU_READY   = 1,
    parameter int LOAD_READY  = 3,
    parameter int EARLY_EXTRA = 1,
    parameter int CNT_W       = 16,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rf_valid,
    input  logic [ADDR_W-1:0] rf_rs,
    input  logic [ADDR_W-1:0] rf_rt,
    input  logic              rf_use_rs,
    input  logic              rf_use_rt,
    input  logic              rf_early,
    input  logic              rf_wr_en,
    input  logic [ADDR_W-1:0] rf_dst,
    input  logic              rf_is_load,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic              stall,
    output logic [SEL_W-1:0]  rf_fwd_rs,
    output logic [SEL_W-1:0]  rf_fwd_rt,
    output logic [SEL_W-1:0]  ex_fwd_rs,
    output logic [SEL_W-1:0]  ex_fwd_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned ALU_R   = ALU_READY;
    localparam int unsigned LD_R    = LOAD_READY;
    localparam int unsigned EXTRA   = EARLY_EXTRA;

    // Scoreboard entries, index k = stages downstream of RF
    logic              v_q   [1:DEPTH];
    logic              v_d   [1:DEPTH];
    logic [ADDR_W-1:0] dst_q [1:DEPTH];
    logic [ADDR_W-1:0] dst_d [1:DEPTH];
    logic              ld_q  [1:DEPTH];
    logic              ld_d  [1:DEPTH];

    logic [SEL_W-1:0]  ex_fwd_rs_q, ex_fwd_rs_d;
    logic [SEL_W-1:0]  ex_fwd_rt_q, ex_fwd_rt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Per-operand lookup results (0 = rs, 1 = rt)
    logic [ADDR_W-1:0] op_src  [2];
    logic              op_use  [2];
    logic              op_hit  [2];
    logic              op_rdy  [2];
    logic              hit_ld  [2];
    int unsigned       hit_idx [2];
    int unsigned       need    [2];

    always_comb begin
        op_src[0] = rf_rs;
        op_src[1] = rf_rt;
        op_use[0] = rf_use_rs;
        op_use[1] = rf_use_rt;
    end

    // Scan oldest to youngest so the youngest matching producer is the one kept
    always_comb begin
        for (int unsigned op = 0; op < 2; op++) begin
            op_hit[op]  = 1'b0;
            hit_idx[op] = 0;
            hit_ld[op]  = 1'b0;
            for (int unsigned k = DEPTH_U; k >= 1; k--) begin
                if (v_q[k] && (dst_q[k] == op_src[op]) &&
                    (op_src[op] != '0) && op_use[op]) begin
                    op_hit[op]  = 1'b1;
                    hit_idx[op] = k;
                    hit_ld[op]  = ld_q[k];
                end
            end
            need[op] = hit_ld[op] ? LD_R : ALU_R;
            // EX consumers get the value one stage later, RF consumers need extra slack
            op_rdy[op] = rf_early ? (hit_idx[op] >= need[op] + EXTRA)
                                  : (hit_idx[op] + 1 >= need[op]);
        end
    end

    always_comb begin
        stall = rf_valid && !flush &&
                ((op_hit[0] && !op_rdy[0]) || (op_hit[1] && !op_rdy[1]));

        rf_fwd_rs = (rf_early && op_hit[0] && op_rdy[0]) ? SEL_W'(hit_idx[0]) : '0;
        rf_fwd_rt = (rf_early && op_hit[1] && op_rdy[1]) ? SEL_W'(hit_idx[1]) : '0;

        ex_fwd_rs_d = '0;
        ex_fwd_rt_d = '0;
        if (!stall && !flush && !rf_early) begin
            if (op_hit[0] && (hit_idx[0] + 1 <= DEPTH_U))
                ex_fwd_rs_d = SEL_W'(hit_idx[0] + 1);
            if (op_hit[1] && (hit_idx[1] + 1 <= DEPTH_U))
                ex_fwd_rt_d = SEL_W'(hit_idx[1] + 1);
        end

        v_d[1]   = rf_valid && rf_wr_en && (rf_dst != '0) && !stall && !flush;
        dst_d[1] = rf_dst;
        ld_d[1]  = rf_is_load;
        for (int unsigned k = 2; k <= DEPTH_U; k++) begin
            v_d[k]   = v_q[k-1];
            dst_d[k] = dst_q[k-1];
            ld_d[k]  = ld_q[k-1];
        end

        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (stall && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= DEPTH_U; k++) begin
                v_q[k]   <= 1'b0;
                dst_q[k] <= '0;
                ld_q[k]  <= 1'b0;
            end
            ex_fwd_rs_q <= '0;
            ex_fwd_rt_q <= '0;
            cnt_q       <= '0;
        end else begin
            for (int unsigned k = 1; k <= DEPTH_U; k++) begin
                v_q[k]   <= v_d[k];
                dst_q[k] <= dst_d[k];
                ld_q[k]  <= ld_d[k];
            end
            ex_fwd_rs_q <= ex_fwd_rs_d;
            ex_fwd_rt_q <= ex_fwd_rt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_fwd_rs = ex_fwd_rs_q;
    assign ex_fwd_rt = ex_fwd_rt_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
module tb_fwd_hazard_scoreboard;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 8;
    localparam int SEL_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rf_valid;
    logic [ADDR_W-1:0] rf_rs, rf_rt, rf_dst;
    logic              rf_use_rs, rf_use_rt, rf_early, rf_wr_en, rf_is_load;
    logic              flush, clr_cnt;
    logic              stall;
    logic [SEL_W-1:0]  rf_fwd_rs, rf_fwd_rt, ex_fwd_rs, ex_fwd_rt;
    logic [CNT_W-1:0]  stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_scoreboard #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ALU_READY(1), .LOAD_READY(3),
        .EARLY_EXTRA(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rf_valid(rf_valid),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_use_rs(rf_use_rs), .rf_use_rt(rf_use_rt),
        .rf_early(rf_early), .rf_wr_en(rf_wr_en), .rf_dst(rf_dst),
        .rf_is_load(rf_is_load), .flush(flush), .clr_cnt(clr_cnt),
        .stall(stall), .rf_fwd_rs(rf_fwd_rs), .rf_fwd_rt(rf_fwd_rt),
        .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_valid = 0; rf_rs = 0; rf_rt = 0; rf_use_rs = 0; rf_use_rt = 0;
        rf_early = 0; rf_wr_en = 0; rf_dst = 0; rf_is_load = 0;
        flush = 0; clr_cnt = 0;
    endtask

    task automatic drain();
        idle();
        repeat (3) cyc();
    endtask

    task automatic push(input logic [ADDR_W-1:0] dst, input logic is_ld);
        idle();
        rf_valid = 1; rf_wr_en = 1; rf_dst = dst; rf_is_load = is_ld;
        cyc();
    endtask

    task automatic load_loop_inputs();
        idle();
        rf_valid = 1; rf_wr_en = 1; rf_dst = 7; rf_is_load = 1;
        rf_early = 1; rf_use_rs = 1; rf_rs = 7;
    endtask

    int n_stall;

    initial begin
        // Reset with a writer and reader present
        idle();
        rst_n = 0; rf_valid = 1; rf_use_rs = 1; rf_rs = 5; rf_wr_en = 1; rf_dst = 5;
        cyc(); cyc();
        check("rst_stall", stall, 0);
        check("rst_rf_fwd_rs", rf_fwd_rs, 0);
        check("rst_rf_fwd_rt", rf_fwd_rt, 0);
        check("rst_ex_fwd_rs", ex_fwd_rs, 0);
        check("rst_ex_fwd_rt", ex_fwd_rt, 0);
        check("rst_cnt", stall_cnt, 0);
        rst_n = 1;
        idle(); rf_valid = 1; rf_use_rs = 1; rf_rs = 5; rf_early = 1;
        #1;
        check("post_rst_stall", stall, 0);
        check("post_rst_rf_fwd", rf_fwd_rs, 0);
        drain();

        // ALU producer -> ALU consumer
        push(5, 0);
        idle(); rf_valid = 1; rf_use_rs = 1; rf_rs = 5;
        #1;
        check("alu_use_stall", stall, 0);
        check("alu_use_rf_fwd", rf_fwd_rs, 0);
        cyc();
        check("alu_use_ex_rs", ex_fwd_rs, 2);
        check("alu_use_ex_rt", ex_fwd_rt, 0);
        rf_rs = 6;
        cyc();
        check("nomatch_ex_rs", ex_fwd_rs, 0);
        idle(); rf_valid = 1; rf_use_rt = 1; rf_rt = 5;
        #1;
        check("wb_stage_stall", stall, 0);
        cyc();
        check("wb_stage_ex_rt", ex_fwd_rt, 0);
        drain();

        // Load-use: one stall cycle then EX forward from stage 3
        push(7, 1);
        idle(); rf_valid = 1; rf_use_rt = 1; rf_rt = 7;
        #1;
        check("ld_use_stall", stall, 1);
        cyc();
        check("ld_use_stall_gone", stall, 0);
        check("ld_use_cnt", stall_cnt, 1);
        check("ld_use_ex_bubble", ex_fwd_rt, 0);
        cyc();
        check("ld_use_ex_rt", ex_fwd_rt, 3);
        drain();

        // jr on $31 after ALU writer
        push(31, 0);
        idle(); rf_valid = 1; rf_early = 1; rf_use_rs = 1; rf_rs = 31;
        #1;
        check("jr_stall", stall, 1);
        check("jr_rf_fwd_wait", rf_fwd_rs, 0);
        cyc();
        check("jr_stall_gone", stall, 0);
        check("jr_rf_fwd", rf_fwd_rs, 2);
        check("jr_cnt", stall_cnt, 2);
        cyc();
        check("jr_ex_fwd", ex_fwd_rs, 0);
        drain();

        // beq after load: waits for the load to retire
        push(8, 1);
        idle(); rf_valid = 1; rf_early = 1; rf_use_rs = 1; rf_use_rt = 1; rf_rs = 8; rf_rt = 9;
        #1;
        check("beq_stall1", stall, 1);
        cyc();
        check("beq_stall2", stall, 1);
        cyc();
        check("beq_stall3", stall, 1);
        cyc();
        check("beq_stall_end", stall, 0);
        check("beq_rf_fwd", rf_fwd_rs, 0);
        check("beq_cnt", stall_cnt, 5);
        drain();

        // Youngest producer wins; rs == rt
        push(4, 1);
        push(4, 0);
        idle(); rf_valid = 1; rf_use_rs = 1; rf_use_rt = 1; rf_rs = 4; rf_rt = 4;
        #1;
        check("dup_stall", stall, 0);
        cyc();
        check("dup_ex_rs", ex_fwd_rs, 2);
        check("dup_ex_rt", ex_fwd_rt, 2);
        drain();

        // r0 writer never tracked
        push(0, 0);
        idle(); rf_valid = 1; rf_early = 1; rf_use_rs = 1; rf_rs = 0;
        #1;
        check("r0_stall", stall, 0);
        check("r0_rf_fwd", rf_fwd_rs, 0);
        drain();

        // Flush during load-use stall: no stall, no count, no push
        push(7, 1);
        idle(); rf_valid = 1; rf_use_rt = 1; rf_rt = 7; rf_wr_en = 1; rf_dst = 9;
        #1;
        check("flush_pre_stall", stall, 1);
        flush = 1;
        #1;
        check("flush_stall", stall, 0);
        cyc();
        check("flush_cnt", stall_cnt, 5);
        check("flush_ex_rt", ex_fwd_rt, 0);
        idle(); rf_valid = 1; rf_early = 1; rf_use_rs = 1; rf_rs = 9;
        #1;
        check("flush_no_push", stall, 0);
        drain();

        // Reset during a stall drops the producer
        push(10, 1);
        idle(); rf_valid = 1; rf_early = 1; rf_use_rs = 1; rf_rs = 10;
        #1;
        check("midrst_pre_stall", stall, 1);
        rst_n = 0;
        cyc();
        rst_n = 1;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_cnt", stall_cnt, 0);
        drain();

        // clr_cnt wins over increment
        load_loop_inputs();
        cyc();
        check("clr_pre_stall", stall, 1);
        clr_cnt = 1;
        cyc();
        check("clr_with_stall", stall_cnt, 0);
        drain();
        check("clr_idle_cnt", stall_cnt, 0);

        // Saturation: 2^CNT_W + 3 stalls
        load_loop_inputs();
        #1;
        n_stall = 0;
        for (int i = 0; i < 2000 && n_stall < 255; i++) begin
            if (stall) n_stall++;
            cyc();
        end
        check("sat_reach_255", n_stall, 255);
        check("cnt_at_max", stall_cnt, 255);
        for (int i = 0; i < 2000 && n_stall < (1 << CNT_W) + 3; i++) begin
            if (stall) n_stall++;
            cyc();
        end
        check("sat_reach_all", n_stall, (1 << CNT_W) + 3);
        check("cnt_saturated", stall_cnt, 255);
        clr_cnt = 1;
        cyc();
        check("cnt_cleared", stall_cnt, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
